// File: rtl/load_cmd_queue_if.sv
// Producer/consumer bundle for the load command queue: request handshake, flush,
// issued load pulse and occupancy status.
interface load_cmd_queue_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              req_valid_i;
    logic [DATA_W-1:0] req_val_i;
    logic              req_ready_o;
    logic              flush_i;
    logic              load_o;
    logic [DATA_W-1:0] load_val_o;
    logic [LVL_W-1:0]  level_o;
    logic              empty_o;
    logic              full_o;

    modport master (
        output req_valid_i, req_val_i, flush_i,
        input  req_ready_o, load_o, load_val_o, level_o, empty_o, full_o
    );

    modport slave (
        input  req_valid_i, req_val_i, flush_i,
        output req_ready_o, load_o, load_val_o, level_o, empty_o, full_o
    );
endinterface

// File: rtl/load_cmd_queue.sv
// Buffers counter load requests and issues them in order as one-cycle load pulses,
// keeping at least GAP idle cycles between consecutive pulses.
module load_cmd_queue #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int GAP    = 2
) (
    input  logic            clk,
    input  logic            reset,
    load_cmd_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t            state, state_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic              load, load_n;
    logic [DATA_W-1:0] load_val, load_val_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              empty, full, ready, push, pop;

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign ready = !full && reset;
    assign push  = bus.req_valid_i && ready && !bus.flush_i;

    assign bus.req_ready_o = ready;
    assign bus.load_o      = load;
    assign bus.load_val_o  = load_val;
    assign bus.level_o     = level;
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;

    always_comb begin
        state_n    = state;
        gap_cnt_n  = gap_cnt;
        load_n     = 1'b0;
        load_val_n = load_val;
        pop        = 1'b0;
        if (bus.flush_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop        = 1'b1;
                        load_n     = 1'b1;
                        load_val_n = mem[rd_ptr];
                        state_n    = ISSUE;
                    end
                end
                ISSUE: begin
                    if (GAP == 0) begin
                        if (!empty) begin
                            pop        = 1'b1;
                            load_n     = 1'b1;
                            load_val_n = mem[rd_ptr];
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        gap_cnt_n = GAP_W'(GAP - 1);
                        state_n   = HOLD;
                    end
                end
                HOLD: begin
                    // The last hold cycle issues directly so load_o is low for exactly GAP cycles.
                    if (gap_cnt != '0) begin
                        gap_cnt_n = gap_cnt - GAP_W'(1);
                    end else if (!empty) begin
                        pop        = 1'b1;
                        load_n     = 1'b1;
                        load_val_n = mem[rd_ptr];
                        state_n    = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            load     <= 1'b0;
            load_val <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else if (bus.flush_i) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            load     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            state    <= state_n;
            gap_cnt  <= gap_cnt_n;
            load     <= load_n;
            load_val <= load_val_n;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level    <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.req_val_i;
    end
endmodule

// File: tb/tb_load_cmd_queue.sv
// Directed bench: reset, latency, gap spacing, back-to-back issue, flush and mid-burst reset.
module tb_load_cmd_queue;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_cmd_queue_if #(.DATA_W(4), .DEPTH(4)) if2 ();
    load_cmd_queue_if #(.DATA_W(4), .DEPTH(4)) if0 ();

    load_cmd_queue #(.DATA_W(4), .DEPTH(4), .GAP(2)) u_dut  (.clk(clk), .reset(reset), .bus(if2.slave));
    load_cmd_queue #(.DATA_W(4), .DEPTH(4), .GAP(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

    int p2_val[$], p2_cyc[$], p0_val[$], p0_cyc[$];
    logic saw_full = 1'b0;
    int   max_lvl  = 0;

    always @(negedge clk) begin
        if (if2.load_o) begin p2_val.push_back(int'(if2.load_val_o)); p2_cyc.push_back(cyc); end
        if (if0.load_o) begin p0_val.push_back(int'(if0.load_val_o)); p0_cyc.push_back(cyc); end
        if (if2.level_o == 3'd4 && !if2.req_ready_o) saw_full = 1'b1;
        if (int'(if2.level_o) > max_lvl) max_lvl = int'(if2.level_o);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        p2_val.delete(); p2_cyc.delete(); p0_val.delete(); p0_cyc.delete();
    endtask

    // Producer holds valid through base..base+n-1, then checks order and spacing of pulses.
    task automatic run_burst(input int base, input int n);
        int k;
        clear_logs();
        for (int i = 0; i < n; i++) begin
            if2.req_valid_i = 1'b1;
            if2.req_val_i   = 4'(base + i);
            k = 0;
            while (!if2.req_ready_o && k < 50) begin step(); k++; end
            chk("burst_ready_wait", int'(k < 50), 1);
            step();
        end
        if2.req_valid_i = 1'b0;
        k = 0;
        while (p2_val.size() < n && k < 200) begin step(); k++; end
        step(4);
        chk("burst_pulse_cnt", p2_val.size(), n);
        for (int i = 0; i < n && i < p2_val.size(); i++) begin
            chk("burst_val", p2_val[i], base + i);
            if (i > 0) chk("burst_spacing", p2_cyc[i] - p2_cyc[i-1], 3);
        end
        chk("burst_empty", int'(if2.empty_o), 1);
    endtask

    initial begin
        reset = 1'b0;
        if2.req_valid_i = 1'b1; if2.req_val_i = 4'd5; if2.flush_i = 1'b0;
        if0.req_valid_i = 1'b0; if0.req_val_i = 4'd0; if0.flush_i = 1'b0;

        // 1: reset with valid held
        step();
        chk("rst_ready",    int'(if2.req_ready_o), 0);
        chk("rst_load",     int'(if2.load_o), 0);
        chk("rst_load_val", int'(if2.load_val_o), 0);
        chk("rst_level",    int'(if2.level_o), 0);
        chk("rst_empty",    int'(if2.empty_o), 1);
        chk("rst_full",     int'(if2.full_o), 0);
        step();
        chk("rst_level2",   int'(if2.level_o), 0);
        reset = 1'b1;
        if2.req_valid_i = 1'b0;
        #1;
        chk("post_rst_ready", int'(if2.req_ready_o), 1);
        clear_logs();
        step(3);
        chk("post_rst_level",   int'(if2.level_o), 0);
        chk("post_rst_nopulse", p2_val.size(), 0);
        chk("post_rst_empty0",  int'(if0.empty_o), 1);

        // 2: single push latency
        if2.req_valid_i = 1'b1; if2.req_val_i = 4'd3;
        step();
        if2.req_valid_i = 1'b0;
        chk("lat_n_load",   int'(if2.load_o), 0);
        chk("lat_n_level",  int'(if2.level_o), 1);
        step();
        chk("lat_n1_load",  int'(if2.load_o), 1);
        chk("lat_n1_val",   int'(if2.load_val_o), 3);
        chk("lat_n1_level", int'(if2.level_o), 0);
        step();
        chk("lat_n2_load",  int'(if2.load_o), 0);
        chk("lat_n2_hold",  int'(if2.load_val_o), 3);
        step(5);

        // 3: GAP=2 bursts; second one long enough to fill the queue
        run_burst(1, 5);
        saw_full = 1'b0; max_lvl = 0;
        run_burst(9, 7);
        chk("full_ready_low", int'(saw_full), 1);
        chk("max_level",      max_lvl, 4);

        // 4: GAP=0 back-to-back
        clear_logs();
        if0.req_valid_i = 1'b1; if0.req_val_i = 4'd7; step();
        if0.req_val_i = 4'd8; step();
        if0.req_val_i = 4'd9; step();
        if0.req_valid_i = 1'b0;
        step(4);
        chk("g0_cnt", p0_val.size(), 3);
        for (int i = 0; i < 3 && i < p0_val.size(); i++) begin
            chk("g0_val", p0_val[i], 7 + i);
            if (i > 0) chk("g0_consec", p0_cyc[i] - p0_cyc[i-1], 1);
        end
        chk("g0_load_low", int'(if0.load_o), 0);
        chk("g0_empty",    int'(if0.empty_o), 1);

        // 5: flush while in HOLD at level 3, with a concurrent push
        clear_logs();
        for (int v = 1; v <= 4; v++) begin
            if2.req_valid_i = 1'b1; if2.req_val_i = 4'(v); step();
        end
        chk("fl_pre_level", int'(if2.level_o), 3);
        chk("fl_pre_load",  int'(if2.load_o), 0);
        if2.flush_i = 1'b1; if2.req_val_i = 4'd6;
        step();
        if2.flush_i = 1'b0; if2.req_valid_i = 1'b0;
        chk("fl_level",    int'(if2.level_o), 0);
        chk("fl_empty",    int'(if2.empty_o), 1);
        chk("fl_load",     int'(if2.load_o), 0);
        chk("fl_val_keep", int'(if2.load_val_o), 1);
        step(10);
        chk("fl_pulses", p2_val.size(), 1);
        if (p2_val.size() > 0) chk("fl_first", p2_val[0], 1);

        // 6: reset mid-burst with level 2 and load_o high
        for (int v = 1; v <= 4; v++) begin
            if2.req_valid_i = 1'b1; if2.req_val_i = 4'(v); step();
        end
        if2.req_valid_i = 1'b0;
        step();
        chk("mb_load",  int'(if2.load_o), 1);
        chk("mb_level", int'(if2.level_o), 2);
        chk("mb_val",   int'(if2.load_val_o), 2);
        reset = 1'b0;
        #1;
        chk("mb_rst_ready", int'(if2.req_ready_o), 0);
        step();
        chk("mb_rst_load",  int'(if2.load_o), 0);
        chk("mb_rst_val",   int'(if2.load_val_o), 0);
        chk("mb_rst_level", int'(if2.level_o), 0);
        chk("mb_rst_empty", int'(if2.empty_o), 1);
        chk("mb_rst_full",  int'(if2.full_o), 0);
        reset = 1'b1;
        clear_logs();
        step(10);
        chk("mb_no_pulse", p2_val.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
